// File: rtl/flag_adder_pkg.sv
// Shared op encodings and status-flag bundle for the pipelined flag adder.
package flag_adder_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBC = 2'd3;

  typedef struct packed {
    logic sign;
    logic zero;
    logic overflow;
    logic carry;
    logic parity;
  } flags_t;

  // SUB and SBC add the inverted y operand
  function automatic logic op_inverts_y(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/flag_adder_pipe_add_slice.sv
// N-bit ripple-style adder slice with carry in and carry out.
module add_slice #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  assign {cout_c, sum_c} = {1'b0, a} + {1'b0, b} + (N+1)'(cin);

endmodule

// File: rtl/flag_adder_pipe.sv
// Two-stage add/sub pipeline (low half, then high half) with status flags,
// carry chaining across ops, valid/ready backpressure and sticky overflow.
module flag_adder_pipe
  import flag_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_parity,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned H = WIDTH / 2;

  logic             en;
  logic [WIDTH-1:0] y_eff;
  logic             cin;
  logic             fwd_c;
  logic [H-1:0]     lo_sum;
  logic             lo_cout;

  logic             s1_valid;
  logic [H-1:0]     s1_lo_sum;
  logic             s1_lo_c;
  logic [H-1:0]     s1_x_hi;
  logic [H-1:0]     s1_y_hi;

  logic [H-1:0]     hi_sum;
  logic             hi_cout;
  logic [WIDTH-1:0] z_c;
  flags_t           flags_nxt;
  flags_t           flags_q;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Chained ops take the carry of the bundle just ahead, whether still in s1 or done
  assign fwd_c = s1_valid ? hi_cout : flags_q.carry;

  always_comb begin
    y_eff = in_y;
    cin   = 1'b0;
    if (op_inverts_y(in_op)) y_eff = ~in_y;
    case (in_op)
      OP_ADD:  cin = 1'b0;
      OP_SUB:  cin = 1'b1;
      default: cin = fwd_c;
    endcase
  end

  add_slice #(.N(H)) u_lo (
    .a      (in_x[H-1:0]),
    .b      (y_eff[H-1:0]),
    .cin    (cin),
    .sum_c  (lo_sum),
    .cout_c (lo_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lo_sum <= '0;
      s1_lo_c   <= 1'b0;
      s1_x_hi   <= '0;
      s1_y_hi   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo_sum <= lo_sum;
        s1_lo_c   <= lo_cout;
        s1_x_hi   <= in_x[WIDTH-1:H];
        s1_y_hi   <= y_eff[WIDTH-1:H];
      end
    end
  end

  add_slice #(.N(H)) u_hi (
    .a      (s1_x_hi),
    .b      (s1_y_hi),
    .cin    (s1_lo_c),
    .sum_c  (hi_sum),
    .cout_c (hi_cout)
  );

  always_comb begin
    z_c                = {hi_sum, s1_lo_sum};
    flags_nxt.sign     = z_c[WIDTH-1];
    flags_nxt.zero     = (z_c == '0);
    flags_nxt.overflow = (s1_x_hi[H-1] == s1_y_hi[H-1]) && (z_c[WIDTH-1] != s1_x_hi[H-1]);
    flags_nxt.carry    = hi_cout;
    flags_nxt.parity   = ~^z_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_z      <= '0;
      flags_q    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (en) out_valid <= s1_valid;
      if (en && s1_valid) begin
        out_z   <= z_c;
        flags_q <= flags_nxt;
      end
      // A new overflow beats a simultaneous clear
      if (out_valid && out_ready && flags_q.overflow) ovf_sticky <= 1'b1;
      else if (clr_sticky)                             ovf_sticky <= 1'b0;
    end
  end

  assign out_sign     = flags_q.sign;
  assign out_zero     = flags_q.zero;
  assign out_overflow = flags_q.overflow;
  assign out_carry    = flags_q.carry;
  assign out_parity   = flags_q.parity;

endmodule

// File: tb/tb_flag_adder_pipe.sv
// Self-checking bench for flag_adder_pipe: directed vectors, corner sequences
// and random traffic scored against an arithmetic reference model.
module tb_flag_adder_pipe;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'd0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_z;
  logic         out_sign, out_zero, out_overflow, out_carry, out_parity;
  logic         ovf_sticky;
  logic         clr_sticky = 1'b0;

  flag_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_sign(out_sign), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_carry(out_carry), .out_parity(out_parity),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] z;
    logic [4:0]   flg;   // {sign, zero, overflow, carry, parity}
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [4:0]   flg;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  int   rx_count = 0;
  res_t exp_q[$];
  logic mcarry = 1'b0;
  logic msticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Arithmetic reference: integer sums, signed range test, population count
  function automatic res_t ref_op(input logic [1:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic cprev);
    int unsigned yp, cin, full;
    int          ssum;
    res_t        r;
    logic [W-1:0] yv;
    case (op)
      2'd0:    begin yv = y;  cin = 0; end
      2'd1:    begin yv = ~y; cin = 1; end
      2'd2:    begin yv = y;  cin = 32'(cprev); end
      default: begin yv = ~y; cin = 32'(cprev); end
    endcase
    yp   = 32'(yv);
    full = 32'(x) + yp + cin;
    ssum = int'($signed(x)) + int'($signed(yv)) + int'(cin);
    r.z  = W'(full);
    r.flg[4] = r.z[W-1];
    r.flg[3] = (full % 65536) == 0;
    r.flg[2] = (ssum > 32767) || (ssum < -32768);
    r.flg[1] = full >= 65536;
    r.flg[0] = ($countones(r.z) % 2) == 0;
    return r;
  endfunction

  // Scoreboard: score every transfer, model sticky flag, record accepts
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mcarry  = 1'b0;
      msticky = 1'b0;
    end else begin
      logic tr, ovf_now;
      res_t e;
      check("sticky", 32'(ovf_sticky), 32'(msticky));
      tr = out_valid && out_ready;
      ovf_now = 1'b0;
      if (tr) begin
        if (exp_q.size() == 0) check("spurious_result", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          check("xfer", {11'd0, out_z, out_sign, out_zero, out_overflow, out_carry, out_parity},
                {11'd0, e});
          ovf_now = e.flg[2];
          rx_count++;
        end
      end
      if (tr && ovf_now) msticky = 1'b1;
      else if (clr_sticky) msticky = 1'b0;
      if (in_valid && in_ready) begin
        e = ref_op(in_op, in_x, in_y, mcarry);
        mcarry = e.flg[1];
        exp_q.push_back(e);
      end
    end
  end

  // Single bundle into an idle pipe; checks two-clock latency and exact result
  task automatic apply_vec(input vec_t v, input string tag);
    in_valid = 1'b1; in_op = v.op; in_x = v.x; in_y = v.y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_z"}, 32'(out_z), 32'(v.z));
    check({tag, "_flags"}, 32'({out_sign, out_zero, out_overflow, out_carry, out_parity}),
          32'(v.flg));
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y;
  endtask

  vec_t vecs[9];

  initial begin
    int start_rx, n;
    vec_t v;

    vecs[0] = '{2'd0, 16'h8fff, 16'h0000, 16'h8fff, 5'b10000};
    vecs[1] = '{2'd0, 16'hffff, 16'h8000, 16'h7fff, 5'b00110};
    vecs[2] = '{2'd0, 16'hffff, 16'h0001, 16'h0000, 5'b01011};
    vecs[3] = '{2'd2, 16'h0000, 16'h0000, 16'h0001, 5'b00000};
    vecs[4] = '{2'd1, 16'h0000, 16'h0001, 16'hffff, 5'b10001};
    vecs[5] = '{2'd3, 16'h0000, 16'h0000, 16'hffff, 5'b10001};
    vecs[6] = '{2'd1, 16'h0005, 16'h0005, 16'h0000, 5'b01011};
    vecs[7] = '{2'd3, 16'h7fff, 16'hffff, 16'h8000, 5'b10100};
    vecs[8] = '{2'd2, 16'h1234, 16'h4321, 16'h5555, 5'b00001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_z", 32'(out_z), 32'(0));
    check("rst_flags", 32'({out_sign, out_zero, out_overflow, out_carry, out_parity}), 32'(0));
    check("rst_sticky", 32'(ovf_sticky), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    check("sticky_holds", 32'(ovf_sticky), 32'(1));

    // Back-to-back ADD then ADC: carry forwarded from stage 2
    drive(2'd0, 16'hffff, 16'h0001);
    @(posedge clk); #1;
    drive(2'd2, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_first_valid", 32'(out_valid), 32'(1));
    check("b2b_first_z", 32'(out_z), 32'h0000);
    check("b2b_first_flags", 32'({out_zero, out_carry, out_parity}), 32'(3'b111));
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_valid", 32'(out_valid), 32'(1));
    check("b2b_second_z", 32'(out_z), 32'h0001);
    check("b2b_second_carry", 32'(out_carry), 32'(0));
    @(posedge clk); #1;

    // Backpressure: three ADDs, consumer stalled for five clocks
    start_rx = rx_count;
    out_ready = 1'b0;
    drive(2'd0, 16'h0001, 16'h0002);
    @(posedge clk); #1;
    drive(2'd0, 16'h0010, 16'h0020);
    @(posedge clk); #1;
    drive(2'd0, 16'h0100, 16'h0200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'(0));
      check($sformatf("bp_hold_z%0d", i), 32'(out_z), 32'h0003);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while ((rx_count - start_rx) < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_count", 32'(rx_count - start_rx), 32'(3));

    // Reset with both stages full
    out_ready = 1'b0;
    drive(2'd0, 16'hffff, 16'h0001);
    @(posedge clk); #1;
    drive(2'd0, 16'hffff, 16'h0001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_before_rst", 32'(out_valid), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_sticky", 32'(ovf_sticky), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    v = '{2'd2, 16'h0000, 16'h0000, 16'h0000, 5'b01001};
    apply_vec(v, "post_rst_adc");

    // Clear and overflow transfer in the same cycle: set wins
    apply_vec('{2'd0, 16'hffff, 16'h8000, 16'h7fff, 5'b00110}, "ovf_again");
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    check("clr_sticky", 32'(ovf_sticky), 32'(0));
    apply_vec('{2'd0, 16'h8000, 16'h8000, 16'h0000, 5'b01111}, "ovf_clr");
    check("set_wins", 32'(ovf_sticky), 32'(1));
    clr_sticky = 1'b0;

    // Random traffic with random stalls and clears
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] pick[4];
      pick[0] = 16'h0000; pick[1] = 16'hffff; pick[2] = 16'h8000; pick[3] = 16'h7fff;
      in_valid   = ($urandom % 3) != 0;
      out_ready  = ($urandom % 4) != 0;
      clr_sticky = ($urandom % 12) == 0;
      in_op      = 2'($urandom % 4);
      in_x       = (($urandom % 4) == 0) ? pick[$urandom % 4] : W'($urandom);
      in_y       = (($urandom % 4) == 0) ? pick[$urandom % 4] : W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
